fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 159 +++++++++++++++
 tb/tb_fetch_queue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a small prefetch queue.
//   Issues one word-aligned read at a time to instruction memory. Each
//   acknowledged word is pushed together with its byte address into a
//   DEPTH-entry FIFO that is presented to decode. A redirect flushes the
//   queue and restarts fetching at a new address. A request that is still
//   in flight when the redirect arrives is drained, and its data is dropped.
//
// Parameters
//   DEPTH      queue depth in 32-bit words (power of two, 2..16)
//   RESET_PC   fetch address loaded at reset
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   redirect        restart the fetch stream at redirect_addr (byte address)
//   mem_req         read request to instruction memory (REQ and DRAIN)
//   mem_addr        word-aligned byte address of the request
//   mem_ack         mem_rdata is valid for the current request
//   mem_rdata       instruction word from memory
//   inst_valid      queue head is presented to decode
//   inst_data       queue-head instruction word
//   inst_pc         queue-head byte address
//   inst_ready      decode takes the head this cycle
//   count           number of queued words
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [31:0]              redirect_addr,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  output logic                     inst_valid,
  output logic [31:0]              inst_data,
  output logic [31:0]              inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    r_state;
  // Address of the outstanding request, or of the next one when idle.
  logic [31:0]   r_fetch_pc;
  // Restart address captured while a stale request drains.
  logic [31:0]   r_pend_pc;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_q_data [DEPTH];
  logic [31:0]   r_q_pc   [DEPTH];

  logic [31:0]   w_redir_pc;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_next;
  logic          w_unused_addr_bits;

  assign w_redir_pc         = {redirect_addr[31:2], 2'b00};
  assign w_unused_addr_bits = ^redirect_addr[1:0];

  // Data returned in the redirect cycle belongs to the old stream.
  assign w_push = (r_state == S_REQ) && mem_ack && !redirect;
  // A pop coincident with redirect is still consumed by decode; the
  // flush below clears the queue regardless.
  assign w_pop  = inst_valid && inst_ready && !redirect;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + CW'(1);
    else if (!w_push && w_pop)
      w_count_next = r_count - CW'(1);
  end

  assign mem_req    = (r_state == S_REQ) || (r_state == S_DRAIN);
  assign mem_addr   = r_fetch_pc;
  assign inst_valid = (r_count != '0);
  // Head outputs read as zero while the queue is empty.
  assign inst_data  = inst_valid ? r_q_data[r_rd_ptr] : 32'h0;
  assign inst_pc    = inst_valid ? r_q_pc[r_rd_ptr]   : 32'h0;
  assign count      = r_count;

  // Control: FSM, fetch address, queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= w_count_next;
      end

      case (r_state)
        S_IDLE: begin
          // Idle means nothing outstanding, so only the queue needs a slot.
          if (redirect) begin
            r_fetch_pc <= w_redir_pc;
            r_state    <= S_REQ;
          end else if (r_count < DEPTH_C) begin
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (redirect) begin
            if (mem_ack) begin
              r_fetch_pc <= w_redir_pc;
            end else begin
              // Keep mem_addr stable until the old request completes.
              r_pend_pc <= w_redir_pc;
              r_state   <= S_DRAIN;
            end
          end else if (mem_ack) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            // Only continue if the next word is guaranteed a slot.
            if (w_count_next >= DEPTH_C)
              r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (mem_ack) begin
            r_fetch_pc <= redirect ? w_redir_pc : r_pend_pc;
            r_state    <= S_REQ;
          end else if (redirect) begin
            r_pend_pc <= w_redir_pc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Queue storage is not reset; occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_data[r_wr_ptr] <= mem_rdata;
      r_q_pc[r_wr_ptr]   <= r_fetch_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [$clog2(DEPTH):0] count;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_addr(redirect_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .inst_valid(inst_valid), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_ready(inst_ready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign mem_rdata = mem_f(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setin(input bit r, input bit rd, input logic [31:0] ra, input bit ak, input bit ry);
    rst = r; redirect = rd; redirect_addr = ra; mem_ack = ak; inst_ready = ry;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input bit e_req, input logic [31:0] e_addr,
                         input bit e_valid, input logic [31:0] e_pc, input int e_cnt);
    chk({tag, ".mem_req"}, 32'(mem_req), 32'(e_req));
    chk({tag, ".mem_addr"}, mem_addr, e_addr);
    chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(e_valid));
    chk({tag, ".count"}, 32'(count), 32'(e_cnt));
    if (e_valid) begin
      chk({tag, ".inst_pc"}, inst_pc, e_pc);
      chk({tag, ".inst_data"}, inst_data, mem_f(e_pc));
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { logic [31:0] d; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  bit          m_out;     // a request is on the bus
  bit          m_stale;   // that request belongs to a flushed stream
  logic [31:0] m_addr;    // address of the request on the bus
  logic [31:0] m_next;    // where fetching continues

  task automatic model_edge(input bit r, input bit rd, input logic [31:0] ra,
                            input bit ak, input bit ry);
    int   size_before;
    bit   was_out, acked, issue;
    ent_t e;
    if (r) begin
      mq.delete(); m_out = 0; m_stale = 0; m_addr = RESET_PC; m_next = RESET_PC;
      return;
    end
    size_before = mq.size();
    was_out = m_out;
    acked   = m_out && ak;
    if (mq.size() > 0 && ry && !rd) void'(mq.pop_front());
    if (acked && !m_stale && !rd) begin
      e.d = mem_f(m_addr); e.pc = m_addr;
      mq.push_back(e);
      m_next = m_addr + 32'd4;
    end
    if (rd) begin
      mq.delete();
      m_next = {ra[31:2], 2'b00};
      if (m_out && !acked) m_stale = 1;
    end
    if (acked) begin m_out = 0; m_stale = 0; end
    if (!m_out) begin
      if (was_out) issue = (mq.size() < DEPTH);
      else         issue = rd || (size_before < DEPTH);
      if (issue) begin m_out = 1; m_addr = m_next; end
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit rst; bit redir; logic [31:0] raddr; bit ack; bit rdy;
    bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc; int e_cnt;
  } vec_t;

  vec_t tbl[16];

  initial begin
    bit          r_rst, r_rd, r_ak, r_ry;
    logic [31:0] r_ra;
    logic [31:0] exp_addr;

    // streaming with ack and ready held high
    tbl[0]  = '{1, 0, 0, 0, 0,  0, 32'h00, 0, 32'h0, 0};
    tbl[1]  = '{0, 0, 0, 1, 1,  1, 32'h00, 0, 32'h0, 0};
    tbl[2]  = '{0, 0, 0, 1, 1,  1, 32'h04, 1, 32'h0, 1};
    tbl[3]  = '{0, 0, 0, 1, 1,  1, 32'h08, 1, 32'h4, 1};
    tbl[4]  = '{0, 0, 0, 1, 1,  1, 32'h0C, 1, 32'h8, 1};
    // fill with decode stalled, then a single pop
    tbl[5]  = '{1, 0, 0, 0, 0,  0, 32'h00, 0, 32'h0, 0};
    tbl[6]  = '{0, 0, 0, 1, 0,  1, 32'h00, 0, 32'h0, 0};
    tbl[7]  = '{0, 0, 0, 1, 0,  1, 32'h04, 1, 32'h0, 1};
    tbl[8]  = '{0, 0, 0, 1, 0,  1, 32'h08, 1, 32'h0, 2};
    tbl[9]  = '{0, 0, 0, 1, 0,  1, 32'h0C, 1, 32'h0, 3};
    tbl[10] = '{0, 0, 0, 1, 0,  0, 32'h10, 1, 32'h0, 4};
    tbl[11] = '{0, 0, 0, 1, 0,  0, 32'h10, 1, 32'h0, 4};
    tbl[12] = '{0, 0, 0, 1, 1,  0, 32'h10, 1, 32'h4, 3};
    tbl[13] = '{0, 0, 0, 0, 0,  1, 32'h10, 1, 32'h4, 3};
    // reset with count=3 and a request pending
    tbl[14] = '{1, 0, 0, 0, 0,  0, 32'h00, 0, 32'h0, 0};
    tbl[15] = '{0, 0, 0, 0, 0,  1, 32'h00, 0, 32'h0, 0};

    setin(1, 0, 0, 0, 0);
    cycle();

    for (int i = 0; i < 16; i++) begin
      setin(tbl[i].rst, tbl[i].redir, tbl[i].raddr, tbl[i].ack, tbl[i].rdy);
      cycle();
      chk_out($sformatf("tbl%0d", i), tbl[i].e_req, tbl[i].e_addr,
              tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_cnt);
      if (tbl[i].rst) begin
        chk($sformatf("tbl%0d.rst_data", i), inst_data, 32'h0);
        chk($sformatf("tbl%0d.rst_pc", i), inst_pc, 32'h0);
      end
    end

    // stale request drained after redirect, ack delayed
    setin(1, 0, 0, 0, 0); cycle();
    setin(0, 0, 0, 1, 0); cycle(); chk_out("drn.start", 1, 32'h0, 0, 0, 0);
    cycle();                        chk_out("drn.w0", 1, 32'h4, 1, 32'h0, 1);
    cycle();                        chk_out("drn.w1", 1, 32'h8, 1, 32'h0, 2);
    setin(0, 0, 0, 0, 0); cycle(); chk_out("drn.hold", 1, 32'h8, 1, 32'h0, 2);
    setin(0, 1, 32'h103, 0, 0); cycle(); chk_out("drn.redir", 1, 32'h8, 0, 0, 0);
    setin(0, 0, 0, 0, 0); cycle(); chk_out("drn.wait1", 1, 32'h8, 0, 0, 0);
    cycle();                        chk_out("drn.wait2", 1, 32'h8, 0, 0, 0);
    setin(0, 0, 0, 1, 0); cycle(); chk_out("drn.ack", 1, 32'h100, 0, 0, 0);
    cycle();                        chk_out("drn.new", 1, 32'h104, 1, 32'h100, 1);

    // redirect coincident with ack and with a pop of head 0x0
    setin(1, 0, 0, 0, 0); cycle();
    setin(0, 0, 0, 0, 0); cycle(); chk_out("coin.start", 1, 32'h0, 0, 0, 0);
    setin(0, 0, 0, 1, 0); cycle(); chk_out("coin.w0", 1, 32'h4, 1, 32'h0, 1);
    setin(0, 1, 32'h200, 1, 1); cycle(); chk_out("coin.redir", 1, 32'h200, 0, 0, 0);
    setin(0, 0, 0, 1, 0); cycle(); chk_out("coin.new", 1, 32'h204, 1, 32'h200, 1);

    // address wrap at the top of the address space
    setin(0, 1, 32'hFFFF_FFFC, 1, 1); cycle(); chk_out("wrap.redir", 1, 32'hFFFF_FFFC, 0, 0, 0);
    setin(0, 0, 0, 1, 1); cycle(); chk_out("wrap.top", 1, 32'h0, 1, 32'hFFFF_FFFC, 1);
    cycle();                        chk_out("wrap.zero", 1, 32'h4, 1, 32'h0, 1);

    // randomized traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      r_rst = (i == 0) || ($urandom_range(0, 99) == 0);
      r_rd  = ($urandom_range(0, 99) < 7);
      r_ra  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
      r_ak  = ($urandom_range(0, 9) < 6);
      r_ry  = ($urandom_range(0, 9) < 5);
      setin(r_rst, r_rd, r_ra, r_ak, r_ry);
      @(posedge clk);
      model_edge(r_rst, r_rd, r_ra, r_ak, r_ry);
      #1;
      exp_addr = m_out ? m_addr : m_next;
      chk($sformatf("rnd%0d.mem_req", i), 32'(mem_req), 32'(m_out));
      chk($sformatf("rnd%0d.mem_addr", i), mem_addr, exp_addr);
      chk($sformatf("rnd%0d.inst_valid", i), 32'(inst_valid), 32'(mq.size() > 0));
      chk($sformatf("rnd%0d.count", i), 32'(count), 32'(mq.size()));
      if (mq.size() > 0) begin
        chk($sformatf("rnd%0d.inst_pc", i), inst_pc, mq[0].pc);
        chk($sformatf("rnd%0d.inst_data", i), inst_data, mq[0].d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
